// File: rtl/ysyx_22050612_dmem_responder_if.sv
// ---------------------------------------------------------------------------
// ysyx_22050612_dmem_responder_if
//
// Purpose:
//   Request/response bundle between the EXU load/store unit (master) and the
//   data-memory responder (slave). It carries one valid/ready request channel
//   and one valid/ready response channel.
//
// Signals:
//   req_valid  master->slave  request present
//   req_ready  slave->master  responder can accept a request
//   req_wen    master->slave  1 = store, 0 = load
//   req_addr   master->slave  64-bit byte address (bits [2:0] ignored)
//   req_wdata  master->slave  store data
//   req_wmask  master->slave  byte-lane enables for stores
//   rsp_valid  slave->master  response present
//   rsp_ready  master->slave  master accepts the response
//   rsp_rdata  slave->master  load data (0 for stores and errors)
//   rsp_err    slave->master  address out of range
//
// Modports:
//   master - EXU side, drives the request and rsp_ready
//   slave  - responder side, drives req_ready and the response
// ---------------------------------------------------------------------------
interface ysyx_22050612_dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid,
    input  req_ready,
    output req_wen,
    output req_addr,
    output req_wdata,
    output req_wmask,
    input  rsp_valid,
    output rsp_ready,
    input  rsp_rdata,
    input  rsp_err
  );

  modport slave (
    input  req_valid,
    output req_ready,
    input  req_wen,
    input  req_addr,
    input  req_wdata,
    input  req_wmask,
    output rsp_valid,
    input  rsp_ready,
    output rsp_rdata,
    output rsp_err
  );
endinterface

// File: rtl/ysyx_22050612_dmem_responder.sv
// ---------------------------------------------------------------------------
// ysyx_22050612_dmem_responder
//
// Purpose:
//   Target side of the EXU memory request interface. Accepts one request at a
//   time, performs a 64-bit word access (byte-masked for stores) on an
//   internal array after a fixed latency, then holds the response until the
//   EXU takes it. Also serves as the simulation data memory.
//
// Parameters:
//   DEPTH   - number of 64-bit words in the array
//   BASE    - byte address of word 0
//   LATENCY - cycles from the request-accept edge to rsp_valid (1..15)
//
// Ports:
//   clk    in   clock, all state updates on posedge
//   rst_n  in   synchronous active-low reset
//   bus    slave modport of ysyx_22050612_dmem_responder_if
//
// Optional feature:
//   YSYX_22050612_DMEM_TRACE_EN - when defined, every access edge prints one
//   "dmem R|W addr=.. data=.. mask=.. err=.." line. No functional effect.
//
// Array contents are not reset. Reset mid-transaction abandons the request;
// a store that has not reached its access edge is never written.
// ---------------------------------------------------------------------------
module ysyx_22050612_dmem_responder #(
  parameter int          DEPTH   = 1024,
  parameter logic [63:0] BASE    = 64'h8000_0000,
  parameter int          LATENCY = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  ysyx_22050612_dmem_responder_if.slave       bus
);

  localparam int          IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [63:0] SPAN     = 64'(DEPTH) * 64'd8;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESP
  } state_t;

  // ------------------------------------------------------------------------
  // State and storage
  // ------------------------------------------------------------------------
  state_t       r_state;
  state_t       w_state_next;
  logic [3:0]   r_cnt;
  logic [3:0]   w_cnt_next;

  logic         r_wen;
  logic [63:0]  r_addr;
  logic [63:0]  r_wdata;
  logic [7:0]   r_wmask;

  logic [63:0]  r_rdata;
  logic         r_err;

  logic [63:0]  r_mem [DEPTH];

  // ------------------------------------------------------------------------
  // Decode of the latched request
  // ------------------------------------------------------------------------
  logic         w_accept;
  logic         w_access;
  logic [63:0]  w_offset;
  logic         w_in_range;
  logic [IDX_W-1:0] w_idx;
  logic         w_write;
  logic [7:0]   w_lane_we;

  assign w_accept = (r_state == ST_IDLE) && bus.req_valid;
  assign w_access = (r_state == ST_BUSY) && (r_cnt == 4'd0);

  // Range check on the offset rather than on BASE+SPAN so that the upper
  // bound cannot wrap for a BASE near the top of the address space.
  assign w_offset   = r_addr - BASE;
  assign w_in_range = (r_addr >= BASE) && (w_offset < SPAN);
  assign w_idx      = w_offset[IDX_W+2:3];

  // rst_n gates the write so a store whose access edge coincides with reset
  // is abandoned like any other in-flight store.
  assign w_write = rst_n && w_access && r_wen && w_in_range;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane_we
      assign w_lane_we[gi] = w_write && r_wmask[gi];
    end
  endgenerate

  // ------------------------------------------------------------------------
  // FSM: next state and handshake outputs
  // ------------------------------------------------------------------------
  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          w_state_next = ST_BUSY;
          w_cnt_next   = CNT_INIT;
        end
      end
      ST_BUSY: begin
        if (r_cnt == 4'd0) begin
          w_state_next = ST_RESP;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      ST_RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = 4'd0;
      end
    endcase
  end

  // ------------------------------------------------------------------------
  // FSM state register and response registers
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_rdata <= 64'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_access) begin
        r_err   <= !w_in_range;
        // Registered array read: the response register is the RAM output
        // register, cleared for stores and out-of-range accesses.
        r_rdata <= (w_in_range && !r_wen) ? r_mem[w_idx] : 64'd0;
      end
    end
  end

  // Request fields only need to be valid on the accept edge, so they are
  // captured there and held through BUSY. No reset needed: they are only
  // consumed after an accept.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_wen   <= bus.req_wen;
      r_addr  <= bus.req_addr;
      r_wdata <= bus.req_wdata;
      r_wmask <= bus.req_wmask;
    end
  end

  // Byte-masked write port; lanes with a clear mask bit keep their contents.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (w_lane_we[i]) begin
        r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
      end
    end
  end

  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_err;

`ifdef YSYX_22050612_DMEM_TRACE_EN
  logic [63:0] w_trace_data;
  assign w_trace_data = r_wen ? r_wdata : (w_in_range ? r_mem[w_idx] : 64'd0);

  always_ff @(posedge clk) begin
    if (rst_n && w_access) begin
      $display("dmem %s addr=%h data=%h mask=%h err=%0d",
               r_wen ? "W" : "R", r_addr, w_trace_data, r_wmask,
               !w_in_range);
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_22050612_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_ysyx_22050612_dmem_responder
//
// Purpose:
//   Self-checking bench for the data-memory responder. Expected responses are
//   pushed to a scoreboard queue when a request is driven and popped when the
//   responder raises rsp_valid. A word-level memory model tracks stores.
// ---------------------------------------------------------------------------
module tb_ysyx_22050612_dmem_responder;

  localparam int          DEPTH   = 1024;
  localparam logic [63:0] BASE    = 64'h8000_0000;
  localparam int          LATENCY = 2;
  localparam logic [63:0] END_ADDR = BASE + 64'(DEPTH) * 64'd8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ysyx_22050612_dmem_responder_if bus();

  ysyx_22050612_dmem_responder #(
    .DEPTH   (DEPTH),
    .BASE    (BASE),
    .LATENCY (LATENCY)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  logic [63:0] model [int];
  logic [63:0] exp_rdata_q [$];
  logic        exp_err_q   [$];

  task automatic idle_bus();
    bus.req_valid = 1'b0;
    bus.req_wen   = 1'b0;
    bus.req_addr  = 64'd0;
    bus.req_wdata = 64'd0;
    bus.req_wmask = 8'd0;
    bus.rsp_ready = 1'b0;
  endtask

  // One complete transaction. Entered and left at #1 after a posedge.
  // hold: cycles rsp_ready stays low in RESP; poke: pulse a stray request
  // during the hold window.
  task automatic do_txn(input logic wen, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [7:0] wmask,
                        input int hold, input logic poke, input string name);
    logic        in_rng;
    int          key;
    logic [63:0] exp_rd;
    logic        exp_err;
    logic [63:0] word;
    logic [63:0] got_rd;
    logic        got_err;
    logic [63:0] held;
    int          n;
    int          w;

    in_rng  = (addr >= BASE) && (addr < END_ADDR);
    key     = in_rng ? int'((addr - BASE) >> 3) : 0;
    exp_err = !in_rng;
    exp_rd  = 64'd0;
    if (in_rng && !wen) begin
      exp_rd = model.exists(key) ? model[key] : 64'd0;
    end
    if (in_rng && wen) begin
      word = model.exists(key) ? model[key] : 64'd0;
      for (int i = 0; i < 8; i++) begin
        if (wmask[i]) word[8*i +: 8] = wdata[8*i +: 8];
      end
      model[key] = word;
    end
    exp_rdata_q.push_back(exp_rd);
    exp_err_q.push_back(exp_err);

    bus.req_valid = 1'b1;
    bus.req_wen   = wen;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_wmask = wmask;

    w = 0;
    while (!bus.req_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    tests_run++;
    if (!bus.req_ready) begin
      tests_failed++;
      $display("FAIL %s accept: req_ready=%0b want 1", name, bus.req_ready);
      idle_bus();
      void'(exp_rdata_q.pop_front());
      void'(exp_err_q.pop_front());
      return;
    end
    @(posedge clk); #1;   // accept edge
    idle_bus();

    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    tests_run++;
    if (n !== LATENCY) begin
      tests_failed++;
      $display("FAIL %s latency: got %0d cycles want %0d", name, n, LATENCY);
    end

    exp_rd  = exp_rdata_q.pop_front();
    exp_err = exp_err_q.pop_front();
    if (!bus.rsp_valid) return;

    got_rd  = bus.rsp_rdata;
    got_err = bus.rsp_err;
    tests_run++;
    if (got_rd !== exp_rd) begin
      tests_failed++;
      $display("FAIL %s rdata: got %h want %h", name, got_rd, exp_rd);
    end
    tests_run++;
    if (got_err !== exp_err) begin
      tests_failed++;
      $display("FAIL %s err: got %0b want %0b", name, got_err, exp_err);
    end

    held = bus.rsp_rdata;
    for (int h = 0; h < hold; h++) begin
      if (poke && h == 1) begin
        bus.req_valid = 1'b1;
        bus.req_wen   = 1'b1;
        bus.req_addr  = 64'h8000_0008;
        bus.req_wdata = 64'hDEAD_BEEF_DEAD_BEEF;
        bus.req_wmask = 8'hFF;
      end
      if (poke && h == 2) idle_bus();
      @(posedge clk); #1;
      tests_run++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== held || bus.req_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL %s hold%0d: valid=%0b rdata=%h ready=%0b want 1 %h 0",
                 name, h, bus.rsp_valid, bus.rsp_rdata, bus.req_ready, held);
      end
    end
    idle_bus();

    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    tests_run++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s release: valid=%0b ready=%0b want 0 1",
               name, bus.rsp_valid, bus.req_ready);
    end
    $display("[TB] %s wen=%0b addr=%h rdata=%h err=%0b", name, wen, addr, got_rd, got_err);
  endtask

  task automatic check_reset_outputs(input string name);
    tests_run++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 ||
        bus.rsp_rdata !== 64'd0 || bus.rsp_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s: ready=%0b valid=%0b rdata=%h err=%0b want 1 0 0 0",
               name, bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err);
    end
  endtask

  task automatic test_reset();
    idle_bus();
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    // rsp_ready while nothing is pending must not do anything.
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check_reset_outputs("idle_rsp_ready");
  endtask

  task automatic test_full_store_load();
    do_txn(1'b1, 64'h8000_0008, 64'h1122_3344_5566_7788, 8'hFF, 0, 1'b0, "store_full");
    do_txn(1'b0, 64'h8000_0008, 64'd0, 8'h00, 0, 1'b0, "load_full");
  endtask

  task automatic test_partial_store();
    do_txn(1'b1, 64'h8000_0008, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0F, 0, 1'b0, "store_mask0f");
    do_txn(1'b0, 64'h8000_0008, 64'd0, 8'h00, 0, 1'b0, "load_mask0f");
    do_txn(1'b1, 64'h8000_0008, 64'hCCCC_CCCC_CCCC_CCCC, 8'h00, 0, 1'b0, "store_mask00");
    do_txn(1'b1, 64'h8000_0008, 64'h0000_EE00_0000_0000, 8'h20, 0, 1'b0, "store_mask20");
    do_txn(1'b0, 64'h8000_0008, 64'd0, 8'h00, 0, 1'b0, "load_after_masks");
  endtask

  task automatic test_unaligned();
    do_txn(1'b0, 64'h8000_000D, 64'd0, 8'h00, 0, 1'b0, "load_unaligned");
  endtask

  task automatic test_random_words();
    logic [63:0] a;
    for (int k = 0; k < 6; k++) begin
      a = BASE + {51'd0, 10'($urandom_range(0, DEPTH - 1)), 3'b000};
      do_txn(1'b1, a, {$urandom, $urandom}, 8'hFF, 0, 1'b0, "rand_store");
      do_txn(1'b0, a, 64'd0, 8'h00, 0, 1'b0, "rand_load");
    end
  endtask

  task automatic test_out_of_range();
    do_txn(1'b1, BASE, 64'h5A5A_0000_0000_A5A5, 8'hFF, 0, 1'b0, "store_word0");
    do_txn(1'b1, END_ADDR - 64'd8, 64'h0F0F_1234_5678_F0F0, 8'hFF, 0, 1'b0, "store_last");
    do_txn(1'b0, 64'h7FFF_FFF8, 64'd0, 8'h00, 0, 1'b0, "load_below");
    do_txn(1'b0, END_ADDR, 64'd0, 8'h00, 0, 1'b0, "load_above");
    do_txn(1'b1, END_ADDR, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 1'b0, "store_above");
    do_txn(1'b0, END_ADDR - 64'd8, 64'd0, 8'h00, 0, 1'b0, "load_last");
    do_txn(1'b0, BASE, 64'd0, 8'h00, 0, 1'b0, "load_word0");
  endtask

  task automatic test_back_pressure();
    do_txn(1'b0, 64'h8000_0008, 64'd0, 8'h00, 5, 1'b1, "load_hold5");
    do_txn(1'b0, 64'h8000_0008, 64'd0, 8'h00, 0, 1'b0, "load_after_poke");
  endtask

  task automatic test_reset_mid_busy();
    int stray;
    do_txn(1'b1, 64'h8000_0010, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, 1'b0, "store_pre");
    do_txn(1'b0, 64'h8000_0010, 64'd0, 8'h00, 0, 1'b0, "load_pre");
    bus.req_valid = 1'b1;
    bus.req_wen   = 1'b1;
    bus.req_addr  = 64'h8000_0010;
    bus.req_wdata = 64'hFFFF_0000_FFFF_0000;
    bus.req_wmask = 8'hFF;
    @(posedge clk); #1;   // accept edge (DUT was IDLE)
    idle_bus();
    tests_run++;
    if (bus.req_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL busy_ready: got %0b want 0", bus.req_ready);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_reset_outputs("mid_busy_reset");
    stray = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid !== 1'b0) stray++;
    end
    tests_run++;
    if (stray != 0) begin
      tests_failed++;
      $display("FAIL mid_busy_no_rsp: rsp_valid high %0d cycles want 0", stray);
    end
    do_txn(1'b0, 64'h8000_0010, 64'd0, 8'h00, 0, 1'b0, "load_post_reset");
  endtask

  initial begin
    idle_bus();
    test_reset();
    test_full_store_load();
    test_partial_store();
    test_unaligned();
    test_random_words();
    test_out_of_range();
    test_back_pressure();
    test_reset_mid_busy();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
